keypad_scanner: RTL



---
 rtl/keypad_scanner.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the
// selected row on prescaler ticks, and reports a hex key code with a strobe.
module keypad_scanner #(
    parameter int SCAN_DIV = 12,
    parameter int DEB_CNT  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY,
    output logic       VALID,
    output logic       HELD,
    output logic [1:0] state
);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;
    localparam logic [3:0] DEB_MAX    = 4'(DEB_CNT);

    logic [3:0]          row_s1;
    logic [3:0]          rs;
    logic [SCAN_DIV-1:0] presc;
    logic                tick;
    logic [1:0]          col_idx;
    logic [1:0]          col_next;
    logic [1:0]          row_idx;
    logic [1:0]          row_sel;
    logic [3:0]          deb;
    logic                row_hit;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << c;
        return ~one_hot;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        case ({c, r})
            4'h0: code = 4'h1;  4'h1: code = 4'h4;  4'h2: code = 4'h7;  4'h3: code = 4'h0;
            4'h4: code = 4'h2;  4'h5: code = 4'h5;  4'h6: code = 4'h8;  4'h7: code = 4'hF;
            4'h8: code = 4'h3;  4'h9: code = 4'h6;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
            4'hC: code = 4'hA;  4'hD: code = 4'hB;  4'hE: code = 4'hC;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign tick     = &presc;
    assign col_next = col_idx + 2'd1;
    assign row_hit  = ~rs[row_idx];

    // Lowest-index active row wins when several rows read low.
    always_comb begin
        row_sel = 2'd0;
        if (!rs[0])      row_sel = 2'd0;
        else if (!rs[1]) row_sel = 2'd1;
        else if (!rs[2]) row_sel = 2'd2;
        else if (!rs[3]) row_sel = 2'd3;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_s1  <= 4'b1111;
            rs      <= 4'b1111;
            presc   <= '0;
            state   <= S_SCAN;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            deb     <= 4'd0;
            COL     <= 4'b1110;
            KEY     <= 4'h0;
            VALID   <= 1'b0;
            HELD    <= 1'b0;
        end else begin
            row_s1 <= ROW;
            rs     <= row_s1;
            presc  <= presc + SCAN_DIV'(1);
            VALID  <= 1'b0;
            if (tick) begin
                case (state)
                    S_SCAN: begin
                        if (rs != 4'b1111) begin
                            row_idx <= row_sel;
                            deb     <= 4'd1;
                            if (DEB_MAX == 4'd1) begin
                                KEY   <= key_code(col_idx, row_sel);
                                VALID <= 1'b1;
                                HELD  <= 1'b1;
                                state <= S_PRESSED;
                            end else begin
                                state <= S_DEBOUNCE;
                            end
                        end else begin
                            col_idx <= col_next;
                            COL     <= col_drive(col_next);
                        end
                    end
                    S_DEBOUNCE: begin
                        if (row_hit) begin
                            if (deb + 4'd1 >= DEB_MAX) begin
                                deb   <= DEB_MAX;
                                KEY   <= key_code(col_idx, row_idx);
                                VALID <= 1'b1;
                                HELD  <= 1'b1;
                                state <= S_PRESSED;
                            end else begin
                                deb <= deb + 4'd1;
                            end
                        end else begin
                            // Bounce: give up on this key and move on.
                            state   <= S_SCAN;
                            col_idx <= col_next;
                            COL     <= col_drive(col_next);
                        end
                    end
                    S_PRESSED: begin
                        if (!row_hit) begin
                            deb <= 4'd1;
                            if (DEB_MAX == 4'd1) begin
                                HELD    <= 1'b0;
                                state   <= S_SCAN;
                                col_idx <= col_next;
                                COL     <= col_drive(col_next);
                            end else begin
                                state <= S_RELEASE;
                            end
                        end
                    end
                    default: begin
                        if (!row_hit) begin
                            if (deb + 4'd1 >= DEB_MAX) begin
                                deb     <= DEB_MAX;
                                HELD    <= 1'b0;
                                state   <= S_SCAN;
                                col_idx <= col_next;
                                COL     <= col_drive(col_next);
                            end else begin
                                deb <= deb + 4'd1;
                            end
                        end else begin
                            state <= S_PRESSED;
                        end
                    end
                endcase
            end
        end
    end

endmodule
